// File: rtl/myproject_mul_share_arbiter.sv
// Round-robin arbiter sharing one unsigned multiplier among N_REQ requesters.
// Two-stage pipeline (operands, then result) with tagged valid/ready output.
module myproject_mul_share_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DIN0_WIDTH = 10,
  parameter int DIN1_WIDTH = 8,
  parameter int DOUT_WIDTH = 17
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DIN0_WIDTH-1:0] req_din0,
  input  logic [N_REQ*DIN1_WIDTH-1:0] req_din1,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DOUT_WIDTH-1:0]       res_dout,
  output logic [ID_WIDTH-1:0]         res_id,
  output logic                        busy
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  logic                  va;
  logic                  vb;
  logic [DIN0_WIDTH-1:0] opa;
  logic [DIN1_WIDTH-1:0] opb;
  logic [ID_WIDTH-1:0]   ida;
  logic [ID_WIDTH-1:0]   ptr;

  logic                  adv_a;
  logic                  adv_b;
  logic                  gnt_found;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [ID_WIDTH-1:0]   cand;
  logic [ID_WIDTH-1:0]   ptr_next;
  logic                  fire;
  logic [PROD_WIDTH-1:0] prod_full;

  assign adv_b = !vb || res_ready;
  assign adv_a = !va || adv_b;

  // Scan upward from ptr with wrap; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_WIDTH'((int'(ptr) + k) % N_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign req_ready = (!ap_rst && adv_a && gnt_found)
                   ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  assign fire      = |(req_valid & req_ready);
  assign ptr_next  = (gnt_idx == ID_WIDTH'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  assign prod_full = PROD_WIDTH'(opa) * PROD_WIDTH'(opb);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      va       <= 1'b0;
      vb       <= 1'b0;
      ptr      <= '0;
      opa      <= '0;
      opb      <= '0;
      ida      <= '0;
      res_dout <= '0;
      res_id   <= '0;
    end else begin
      if (adv_b) begin
        vb <= va;
        if (va) begin
          res_dout <= prod_full[DOUT_WIDTH-1:0];
          res_id   <= ida;
        end
      end
      if (adv_a) begin
        va <= fire;
        if (fire) begin
          opa <= req_din0[gnt_idx*DIN0_WIDTH +: DIN0_WIDTH];
          opb <= req_din1[gnt_idx*DIN1_WIDTH +: DIN1_WIDTH];
          ida <= gnt_idx;
        end
      end
      if (fire) ptr <= ptr_next;
    end
  end

  assign res_valid = vb;
  assign busy      = va | vb;

endmodule

// File: tb/tb_myproject_mul_share_arbiter.sv
// Directed self-checking bench for the shared-multiplier round-robin arbiter.
module tb_myproject_mul_share_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [39:0] req_din0;
  logic [31:0] req_din1;
  logic        res_valid;
  logic        res_ready;
  logic [16:0] res_dout;
  logic [1:0]  res_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  myproject_mul_share_arbiter dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_dout  (res_dout),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #2;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_din0[i*10 +: 10] = 10'(a);
    req_din1[i*8 +: 8]   = 8'(b);
  endtask

  task automatic chk_res(input string tag, input int id, input int dout);
    chk({tag, "_valid"}, int'(res_valid), 1);
    chk({tag, "_id"}, int'(res_id), id);
    chk({tag, "_dout"}, int'(res_dout), dout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int since;
    int gid;
    int q[$];

    ap_rst    = 1'b1;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    req_din0  = '0;
    req_din1  = '0;
    tick();
    tick();
    #1;
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dout", int'(res_dout), 0);
    req_valid = 4'b0000;
    ap_rst    = 1'b0;

    // single op from requester 0
    set_op(0, 3, 5);
    req_valid = 4'b0001;
    #1;
    chk("single_grant", int'(req_ready), 1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("single_ready_drop", int'(req_ready), 0);
    chk("single_busy", int'(busy), 1);
    chk("single_not_yet", int'(res_valid), 0);
    tick();
    #1;
    chk_res("single", 0, 15);
    tick();
    #1;
    chk("single_done_valid", int'(res_valid), 0);
    chk("single_done_busy", int'(busy), 0);

    // truncation via requester 3; ptr=1 so the scan wraps ptr back to 0
    set_op(3, 1023, 255);
    req_valid = 4'b1000;
    #1;
    chk("trunc_grant", int'(req_ready), 8);
    tick();
    req_valid = 4'b0000;
    tick();
    #1;
    chk_res("trunc", 3, 129793);
    tick();

    // round robin with every requester valid
    for (int i = 0; i < 4; i++) set_op(i, i + 1, 2);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rr_grant", int'(req_ready), 1 << (k % 4));
      if (k >= 2) chk_res("rr_res", (k - 2) % 4, 2 * ((k - 2) % 4 + 1));
      else chk("rr_res_early", int'(res_valid), 0);
      tick();
      #1;
    end
    req_valid = 4'b0000;
    #1;
    chk_res("rr_tail0", 0, 2);
    tick();
    #1;
    chk_res("rr_tail1", 1, 4);
    tick();
    #1;
    chk("rr_idle", int'(res_valid), 0);

    // backpressure: restart from ptr=0
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    set_op(1, 7, 3);
    set_op(2, 9, 4);
    req_valid = 4'b0110;
    res_ready = 1'b0;
    #1;
    chk("bp_grant1", int'(req_ready), 2);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("bp_grant2", int'(req_ready), 4);
    tick();
    set_op(1, 5, 5);
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_blocked", int'(req_ready), 0);
      chk("bp_busy", int'(busy), 1);
      chk_res("bp_hold", 1, 21);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_resume_grant", int'(req_ready), 2);
    chk_res("bp_first", 1, 21);
    tick();
    req_valid = 4'b0000;
    #1;
    chk_res("bp_second", 2, 36);
    tick();
    #1;
    chk_res("bp_third", 1, 25);
    tick();
    #1;
    chk("bp_drained_valid", int'(res_valid), 0);
    chk("bp_drained_busy", int'(busy), 0);

    // starvation: req 3 always valid, others toggling
    for (int i = 0; i < 4; i++) set_op(i, i + 10, 3);
    since = 0;
    for (int k = 0; k < 20; k++) begin
      req_valid = {1'b1, 3'((k * 5 + 3) % 8)};
      #1;
      if (res_valid) begin
        if (q.size() == 0) chk("sv_underflow", 1, 0);
        else begin
          chk("sv_id", int'(res_id), q[0]);
          chk("sv_dout", int'(res_dout), (q[0] + 10) * 3);
          void'(q.pop_front());
        end
      end
      if (req_ready != 4'b0000) begin
        gid = 0;
        for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
        if (gid == 3) since = 0;
        else since++;
        chk("starve_gap", (since > 3) ? 1 : 0, 0);
        q.push_back(gid);
      end
      tick();
    end
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (res_valid && q.size() != 0) begin
        chk("sv_drain_id", int'(res_id), q[0]);
        void'(q.pop_front());
      end
      tick();
    end
    chk("sv_all_returned", q.size(), 0);

    // reset with two ops in flight under backpressure
    set_op(0, 3, 5);
    set_op(1, 4, 4);
    req_valid = 4'b0011;
    res_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("mid_blocked", int'(req_ready), 0);
    chk("mid_busy", int'(busy), 1);
    chk("mid_valid", int'(res_valid), 1);
    ap_rst = 1'b1;
    #1;
    chk("mid_rst_ready", int'(req_ready), 0);
    tick();
    ap_rst = 1'b0;
    req_valid = 4'b0101;
    set_op(2, 6, 6);
    res_ready = 1'b1;
    #1;
    chk("mid_after_valid", int'(res_valid), 0);
    chk("mid_after_busy", int'(busy), 0);
    chk("mid_after_dout", int'(res_dout), 0);
    chk("mid_first_grant", int'(req_ready), 1);
    tick();
    req_valid = 4'b0000;
    tick();
    #1;
    chk_res("mid_res", 0, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
